// File: rtl/pipe_stage_reg.sv
// Flow-controlled pipeline stage register with optional two-entry skid buffer,
// flush-to-bubble and saturating stall/bubble counters.
module pipe_stage_reg #(
   parameter int unsigned      WIDTH     = 13,
   parameter int               SKID      = 1,
   parameter logic [WIDTH-1:0] RESET_VAL = '0,
   parameter int unsigned      CNTW      = 16
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             flush,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_data,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_data,
   output logic [CNTW-1:0]  stall_cnt,
   output logic [CNTW-1:0]  bubble_cnt
);

   if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {EMPTY, FULL, SKIDFULL} state_t;

      state_t           state_q, state_d;
      logic [WIDTH-1:0] main_q, main_d;
      logic [WIDTH-1:0] skid_q, skid_d;
      logic             rdy_q;
      logic             in_xfer;

      assign in_xfer = in_valid & rdy_q;

      always_comb begin
         state_d = state_q;
         main_d  = main_q;
         skid_d  = skid_q;
         if (flush) begin
            state_d = EMPTY;
            main_d  = RESET_VAL;
            skid_d  = RESET_VAL;
         end else begin
            case (state_q)
               EMPTY: begin
                  if (in_xfer) begin
                     main_d  = in_data;
                     state_d = FULL;
                  end
               end
               FULL: begin
                  if (in_xfer && out_ready) begin
                     main_d = in_data;
                  end else if (in_xfer) begin
                     skid_d  = in_data;
                     state_d = SKIDFULL;
                  end else if (out_ready) begin
                     main_d  = RESET_VAL;
                     state_d = EMPTY;
                  end
               end
               SKIDFULL: begin
                  if (out_ready) begin
                     main_d  = skid_q;
                     skid_d  = RESET_VAL;
                     state_d = FULL;
                  end
               end
               default: begin
                  state_d = EMPTY;
                  main_d  = RESET_VAL;
                  skid_d  = RESET_VAL;
               end
            endcase
         end
      end

      // in_ready is registered from the next state so out_ready never reaches it combinationally
      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            state_q <= EMPTY;
            main_q  <= RESET_VAL;
            skid_q  <= RESET_VAL;
            rdy_q   <= 1'b1;
         end else begin
            state_q <= state_d;
            main_q  <= main_d;
            skid_q  <= skid_d;
            rdy_q   <= (state_d != SKIDFULL);
         end
      end

      assign in_ready  = rdy_q;
      assign out_valid = (state_q != EMPTY);
      assign out_data  = main_q;
   end else begin : g_noskid
      logic             valid_q;
      logic [WIDTH-1:0] data_q;
      logic             in_xfer;
      logic             out_xfer;

      assign in_ready = ~valid_q | out_ready;
      assign in_xfer  = in_valid & in_ready;
      assign out_xfer = valid_q & out_ready;

      always_ff @(posedge clk or posedge reset) begin
         if (reset) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
         end else if (flush) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
         end else if (in_xfer) begin
            valid_q <= 1'b1;
            data_q  <= in_data;
         end else if (out_xfer) begin
            valid_q <= 1'b0;
            data_q  <= RESET_VAL;
         end
      end

      assign out_valid = valid_q;
      assign out_data  = data_q;
   end

   // Counters ignore flush; only reset clears them
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         stall_cnt  <= '0;
         bubble_cnt <= '0;
      end else begin
         if (out_valid && !out_ready && (stall_cnt != '1))
            stall_cnt <= stall_cnt + 1'b1;
         if (!out_valid && out_ready && (bubble_cnt != '1))
            bubble_cnt <= bubble_cnt + 1'b1;
      end
   end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: three instances (skid, no-skid, 4-bit counters)
// checked every cycle against a queue-style occupancy model, plus directed scenarios.
module tb_pipe_stage_reg;

   logic clk = 1'b0;
   logic reset;
   always #5 clk = ~clk;

   logic        iv[3];
   logic        ordy[3];
   logic        fl[3];
   logic [12:0] id[3];

   logic        irdy0, irdy1, irdy2;
   logic        ov0, ov1, ov2;
   logic [12:0] od0, od1, od2;
   logic [15:0] sc0, bc0, sc1, bc1;
   logic [3:0]  sc2, bc2;

   int n_assert = 0;
   int n_fail   = 0;

   pipe_stage_reg #(.WIDTH(13), .SKID(1), .RESET_VAL(13'h0), .CNTW(16)) u_skid (
      .clk(clk), .reset(reset), .flush(fl[0]),
      .in_valid(iv[0]), .in_ready(irdy0), .in_data(id[0]),
      .out_valid(ov0), .out_ready(ordy[0]), .out_data(od0),
      .stall_cnt(sc0), .bubble_cnt(bc0));

   pipe_stage_reg #(.WIDTH(13), .SKID(0), .RESET_VAL(13'h0), .CNTW(16)) u_noskid (
      .clk(clk), .reset(reset), .flush(fl[1]),
      .in_valid(iv[1]), .in_ready(irdy1), .in_data(id[1]),
      .out_valid(ov1), .out_ready(ordy[1]), .out_data(od1),
      .stall_cnt(sc1), .bubble_cnt(bc1));

   pipe_stage_reg #(.WIDTH(13), .SKID(1), .RESET_VAL(13'h0), .CNTW(4)) u_sat (
      .clk(clk), .reset(reset), .flush(fl[2]),
      .in_valid(iv[2]), .in_ready(irdy2), .in_data(id[2]),
      .out_valid(ov2), .out_ready(ordy[2]), .out_data(od2),
      .stall_cnt(sc2), .bubble_cnt(bc2));

   function automatic logic get_rdy(input int k);
      return (k == 0) ? irdy0 : (k == 1) ? irdy1 : irdy2;
   endfunction
   function automatic logic get_ov(input int k);
      return (k == 0) ? ov0 : (k == 1) ? ov1 : ov2;
   endfunction
   function automatic logic [12:0] get_od(input int k);
      return (k == 0) ? od0 : (k == 1) ? od1 : od2;
   endfunction
   function automatic logic [15:0] get_sc(input int k);
      return (k == 0) ? sc0 : (k == 1) ? sc1 : {12'h000, sc2};
   endfunction
   function automatic logic [15:0] get_bc(input int k);
      return (k == 0) ? bc0 : (k == 1) ? bc1 : {12'h000, bc2};
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_assert++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s at %0t: got %h, expected %h", name, $time, act, exp);
      end
   endtask

   // Model: each stage is a FIFO of capacity 2 (skid) or 1 (no skid)
   int          m_cnt[3] = '{0, 0, 0};
   logic [12:0] e0[3]    = '{13'h0, 13'h0, 13'h0};
   logic [12:0] e1[3]    = '{13'h0, 13'h0, 13'h0};
   int          st[3]    = '{0, 0, 0};
   int          bu[3]    = '{0, 0, 0};

   function automatic bit is_skid(input int k);
      return k != 1;
   endfunction
   function automatic int cmax(input int k);
      return (k == 2) ? 15 : 65535;
   endfunction
   function automatic logic m_ready(input int k);
      if (is_skid(k)) return m_cnt[k] < 2;
      return (m_cnt[k] == 0) || ordy[k];
   endfunction
   function automatic logic [12:0] m_data(input int k);
      return (m_cnt[k] > 0) ? e0[k] : 13'h0;
   endfunction

   task automatic step(input int k);
      logic v, r;
      v = m_cnt[k] > 0;
      r = m_ready(k);
      if (v && !ordy[k] && st[k] < cmax(k)) st[k]++;
      if (!v && ordy[k] && bu[k] < cmax(k)) bu[k]++;
      if (fl[k]) begin
         m_cnt[k] = 0;
      end else begin
         if (v && ordy[k]) begin
            e0[k] = e1[k];
            m_cnt[k]--;
         end
         if (iv[k] && r) begin
            if (m_cnt[k] == 0) e0[k] = id[k];
            else e1[k] = id[k];
            m_cnt[k]++;
         end
      end
   endtask

   initial begin
      forever begin
         @(posedge clk or posedge reset);
         for (int k = 0; k < 3; k++) begin
            if (reset) begin
               m_cnt[k] = 0;
               st[k] = 0;
               bu[k] = 0;
            end else begin
               step(k);
            end
         end
      end
   end

   initial begin
      forever begin
         @(negedge clk);
         for (int k = 0; k < 3; k++) begin
            chk($sformatf("in_ready[%0d]", k), 32'(get_rdy(k)), 32'(m_ready(k)));
            chk($sformatf("out_valid[%0d]", k), 32'(get_ov(k)), 32'(m_cnt[k] > 0));
            chk($sformatf("out_data[%0d]", k), 32'(get_od(k)), 32'(m_data(k)));
            chk($sformatf("stall_cnt[%0d]", k), 32'(get_sc(k)), st[k]);
            chk($sformatf("bubble_cnt[%0d]", k), 32'(get_bc(k)), bu[k]);
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      reset = 1'b1;
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; ordy[k] = 1'b0; fl[k] = 1'b0; id[k] = 13'h0;
      end
      tick();
      tick();
      reset = 1'b0;
   endtask

   initial begin
      do_reset();
      chk("rst_valid", 32'(ov0), 0);
      chk("rst_ready", 32'(irdy0), 1);

      // Streaming 1..10 through the skid stage
      for (int i = 1; i <= 10; i++) begin
         iv[0] = 1'b1; id[0] = 13'(i); ordy[0] = 1'b1;
         tick();
         chk("t1_data", 32'(od0), i);
         chk("t1_ready", 32'(irdy0), 1);
      end
      chk("t1_bubble", 32'(bc0), 1);
      iv[0] = 1'b0;
      tick();
      chk("t1_drain_valid", 32'(ov0), 0);
      chk("t1_drain_data", 32'(od0), 0);

      // Backpressure into the skid entry
      do_reset();
      iv[0] = 1'b1; id[0] = 13'h0AA; ordy[0] = 1'b0;
      tick();
      chk("t2_aa", 32'(od0), 32'h0AA);
      id[0] = 13'h0BB;
      tick();
      chk("t2_hold_aa", 32'(od0), 32'h0AA);
      chk("t2_ready_low", 32'(irdy0), 0);
      id[0] = 13'h0CC;
      repeat (3) tick();
      chk("t2_stall", 32'(sc0), 4);
      chk("t2_still_aa", 32'(od0), 32'h0AA);
      ordy[0] = 1'b1;
      tick();
      chk("t2_bb", 32'(od0), 32'h0BB);
      tick();
      chk("t2_cc", 32'(od0), 32'h0CC);
      iv[0] = 1'b0;
      tick();
      chk("t2_empty", 32'(ov0), 0);
      chk("t2_stall_final", 32'(sc0), 4);

      // Flush from SKIDFULL
      do_reset();
      iv[0] = 1'b1; id[0] = 13'h001; ordy[0] = 1'b0;
      tick();
      id[0] = 13'h002;
      tick();
      chk("t3_skidfull", 32'(irdy0), 0);
      iv[0] = 1'b0; fl[0] = 1'b1;
      tick();
      fl[0] = 1'b0;
      chk("t3_flush_valid", 32'(ov0), 0);
      chk("t3_flush_data", 32'(od0), 0);
      chk("t3_flush_ready", 32'(irdy0), 1);
      iv[0] = 1'b1; id[0] = 13'h123; ordy[0] = 1'b1;
      tick();
      iv[0] = 1'b0;
      chk("t3_new_valid", 32'(ov0), 1);
      chk("t3_new_data", 32'(od0), 32'h123);
      tick();
      chk("t3_alone", 32'(ov0), 0);

      // No-skid combinational ready and pass-through replacement
      do_reset();
      iv[1] = 1'b1; id[1] = 13'h011; ordy[1] = 1'b0;
      tick();
      iv[1] = 1'b0;
      #1;
      chk("t4_ready_low", 32'(irdy1), 0);
      ordy[1] = 1'b1; iv[1] = 1'b1; id[1] = 13'h055;
      #1;
      chk("t4_ready_comb", 32'(irdy1), 1);
      tick();
      chk("t4_replace", 32'(od1), 32'h055);
      chk("t4_valid", 32'(ov1), 1);
      iv[1] = 1'b0;
      tick();
      chk("t4_drain_valid", 32'(ov1), 0);
      chk("t4_drain_data", 32'(od1), 0);

      // Asynchronous reset between edges
      do_reset();
      iv[0] = 1'b1; id[0] = 13'h007; ordy[0] = 1'b0;
      tick();
      iv[0] = 1'b0;
      tick();
      tick();
      chk("t5_pre_stall", 32'(sc0), 2);
      #2;
      reset = 1'b1;
      #1;
      chk("t5_async_valid", 32'(ov0), 0);
      chk("t5_async_data", 32'(od0), 0);
      chk("t5_async_stall", 32'(sc0), 0);
      chk("t5_async_bubble", 32'(bc0), 0);
      chk("t5_async_ready", 32'(irdy0), 1);
      reset = 1'b0;

      // Saturation of a 4-bit stall counter
      do_reset();
      iv[2] = 1'b1; id[2] = 13'h007; ordy[2] = 1'b0;
      tick();
      iv[2] = 1'b0;
      repeat (20) tick();
      chk("t6_sat", 32'(sc2), 15);
      chk("t6_hold_data", 32'(od2), 7);
      ordy[2] = 1'b1;
      tick();
      chk("t6_sat_hold", 32'(sc2), 15);

      // Random traffic on all three instances
      do_reset();
      for (int cyc = 0; cyc < 3000; cyc++) begin
         for (int k = 0; k < 3; k++) begin
            iv[k]   = ($urandom_range(0, 3) != 0);
            id[k]   = 13'($urandom);
            ordy[k] = (cyc < 1500) ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 3) == 0);
            fl[k]   = ($urandom_range(0, 19) == 0);
         end
         tick();
      end
      for (int k = 0; k < 3; k++) begin
         iv[k] = 1'b0; fl[k] = 1'b0; ordy[k] = 1'b1;
      end
      repeat (3) tick();

      $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
      $finish;
   end

endmodule
